// File: rtl/tc_mc_pkg.sv
// rtl/tc_mc_pkg.sv - register map, control bits and status layout for the multi-channel timestamp controller
package tc_mc_pkg;

  // Register addresses; ALARM_i lives at ADDR_ALARM_BASE + i
  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_OFFSET     = 1;
  localparam int ADDR_ALARM_BASE = 2;

  // CTRL write bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLEAR = 2;
  localparam int CTRL_LOAD  = 3;
  localparam int CTRL_AUTO  = 8;

  // STATUS read layout at ADDR_CTRL
  localparam int STAT_RUNNING   = 0;
  localparam int STAT_ARMED_LSB = 8;

  typedef struct packed {
    logic start;
    logic stop;
    logic clear;
    logic load;
    logic auto_en;
  } ctrl_cmd_t;

  // Pull the individual command bits out of the low nine bits of a CTRL write
  function automatic ctrl_cmd_t decode_ctrl(input logic [8:0] w);
    ctrl_cmd_t c;
    c.start   = w[CTRL_START];
    c.stop    = w[CTRL_STOP];
    c.clear   = w[CTRL_CLEAR];
    c.load    = w[CTRL_LOAD];
    c.auto_en = w[CTRL_AUTO];
    return c;
  endfunction

endpackage

// File: rtl/timestamp_alarm.sv
// rtl/timestamp_alarm.sv - one armed compare channel producing a single-cycle match strobe
module timestamp_alarm
  import tc_mc_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     wr_en,
  input  logic [COUNTER_WIDTH-1:0] wr_data,
  input  logic [COUNTER_WIDTH-1:0] cnt,
  output logic [COUNTER_WIDTH-1:0] alarm_val,
  output logic                     armed,
  output logic                     pulse
);

  // A write re-arms and wins over a match on the old value; otherwise an exact match fires once and disarms
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      alarm_val <= '0;
      armed     <= 1'b0;
      pulse     <= 1'b0;
    end else if (wr_en) begin
      alarm_val <= wr_data;
      armed     <= 1'b1;
      pulse     <= 1'b0;
    end else if (armed && (cnt == alarm_val)) begin
      armed     <= 1'b0;
      pulse     <= 1'b1;
    end else begin
      pulse     <= 1'b0;
    end
  end

endmodule

// File: rtl/timestamp_controller_mc.sv
// rtl/timestamp_controller_mc.sv - free-running timestamp counter with register port and NUM_ALARMS compare channels
module timestamp_controller_mc
  import tc_mc_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_ALARMS    = 4,
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     running,
  output logic                     auto_start,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic [NUM_ALARMS-1:0]    alarm_pulse,
  output logic [NUM_ALARMS-1:0]    armed
);

  logic                     cmd_fire;
  logic                     ctrl_wr;
  logic                     offset_wr;
  ctrl_cmd_t                ctrl;
  logic [DATA_WIDTH+8:0]    wdata_ext;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] offset_q;
  logic [COUNTER_WIDTH-1:0] alarm_val [NUM_ALARMS];
  logic [DATA_WIDTH+15:0]   status_ext;
  logic [DATA_WIDTH-1:0]    rd_next;
  logic                     unused_bits;

  // Zero-extension lets CTRL bit 8 be decoded even for narrow data buses
  assign wdata_ext   = (DATA_WIDTH+9)'(cmd_wdata);
  assign ctrl        = decode_ctrl(wdata_ext[8:0]);
  assign cmd_fire    = cmd_valid & cmd_ready;
  assign ctrl_wr     = cmd_fire && (cmd_addr == ADDR_WIDTH'(ADDR_CTRL));
  assign offset_wr   = cmd_fire && (cmd_addr == ADDR_WIDTH'(ADDR_OFFSET));
  assign unused_bits = ^{wdata_ext, status_ext};

  // Write port becomes ready on the first edge after reset release and never stalls afterwards
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) cmd_ready <= 1'b0;
    else                cmd_ready <= 1'b1;
  end

  // OFFSET register, CTRL.AUTO level and the running flag (STOP beats START)
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      offset_q   <= '0;
      auto_start <= 1'b0;
      running    <= 1'b0;
    end else begin
      if (offset_wr) offset_q <= cmd_wdata[COUNTER_WIDTH-1:0];
      if (ctrl_wr) begin
        auto_start <= ctrl.auto_en;
        if (ctrl.stop)       running <= 1'b0;
        else if (ctrl.start) running <= 1'b1;
      end
    end
  end

  // Internal counter: LOAD beats CLEAR, and a written value replaces that cycle's increment
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)              cnt <= '0;
    else if (ctrl_wr && ctrl.load)   cnt <= offset_q;
    else if (ctrl_wr && ctrl.clear)  cnt <= '0;
    else if (running)                cnt <= cnt + COUNTER_WIDTH'(1);
  end

  // Registered copy of the counter so alarm strobes line up with the value they matched
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) counter <= '0;
    else                counter <= cnt;
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    logic wr_hit;
    assign wr_hit = cmd_fire && (cmd_addr == ADDR_WIDTH'(ADDR_ALARM_BASE + i));

    timestamp_alarm #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_alarm (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .wr_en         (wr_hit),
      .wr_data       (cmd_wdata[COUNTER_WIDTH-1:0]),
      .cnt           (cnt),
      .alarm_val     (alarm_val[i]),
      .armed         (armed[i]),
      .pulse         (alarm_pulse[i])
    );
  end

  // Read mux: status, live counter or alarm value, zero-filled; unmapped addresses read 0
  always_comb begin
    status_ext                               = '0;
    status_ext[STAT_RUNNING]                 = running;
    status_ext[STAT_ARMED_LSB +: NUM_ALARMS] = armed;
    rd_next = '0;
    if (rd_addr == ADDR_WIDTH'(ADDR_CTRL))        rd_next = status_ext[DATA_WIDTH-1:0];
    else if (rd_addr == ADDR_WIDTH'(ADDR_OFFSET)) rd_next = DATA_WIDTH'(cnt);
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_addr == ADDR_WIDTH'(ADDR_ALARM_BASE + i)) rd_next = DATA_WIDTH'(alarm_val[i]);
    end
  end

  // Read response one cycle after the request
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_next : '0;
    end
  end

endmodule

// File: tb/tb_timestamp_controller_mc.sv
// tb/tb_timestamp_controller_mc.sv - directed vector bench for the multi-channel timestamp controller
module tb_timestamp_controller_mc;

  localparam int CW = 8;
  localparam int NA = 4;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          running;
  logic          auto_start;
  logic [CW-1:0] counter;
  logic [NA-1:0] alarm_pulse;
  logic [NA-1:0] armed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timestamp_controller_mc #(
    .COUNTER_WIDTH (CW),
    .NUM_ALARMS    (NA),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .running       (running),
    .auto_start    (auto_start),
    .counter       (counter),
    .alarm_pulse   (alarm_pulse),
    .armed         (armed)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic [AW-1:0] raddr;
    logic          e_run;
    logic [CW-1:0] e_cnt;
    logic [NA-1:0] e_pulse;
    logic [NA-1:0] e_armed;
    logic          e_auto;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input int wa, input int wd, input logic rd, input int ra,
                     input logic run, input int c, input int p, input int a, input logic au, input int rdat);
    vec_t r;
    r.wr = wr; r.waddr = AW'(wa); r.wdata = DW'(wd); r.rd = rd; r.raddr = AW'(ra);
    r.e_run = run; r.e_cnt = CW'(c); r.e_pulse = NA'(p); r.e_armed = NA'(a); r.e_auto = au;
    r.e_rdata = DW'(rdat);
    vecs.push_back(r);
  endtask

  // Called at a negedge; the write is captured on the following posedge, returns at the next negedge
  task automatic wr(input int a, input int d);
    cmd_valid = 1'b1; cmd_addr = AW'(a); cmd_wdata = DW'(d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] ec;
    int bad_cnt;
    int bad_stray;

    rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; rd_en = 1'b0; rd_addr = '0;

    //            wr wa wd      rd ra  run cnt   p  a  auto rdata
    add(1, 0, 'h0001, 0, 0, 1, 'h00, 0, 0, 0, 0);
    add(0, 0, 0,      1, 1, 1, 'h00, 0, 0, 0, 'h0000);
    add(0, 0, 0,      1, 1, 1, 'h01, 0, 0, 0, 'h0001);
    add(0, 0, 0,      0, 0, 1, 'h02, 0, 0, 0, 0);
    add(1, 0, 'h0002, 0, 0, 0, 'h03, 0, 0, 0, 0);
    add(0, 0, 0,      0, 0, 0, 'h04, 0, 0, 0, 0);
    add(0, 0, 0,      1, 0, 0, 'h04, 0, 0, 0, 'h0000);
    add(1, 1, 'h00FD, 0, 0, 0, 'h04, 0, 0, 0, 0);
    add(1, 2, 'h0001, 0, 0, 0, 'h04, 0, 1, 0, 0);
    add(1, 0, 'h0009, 0, 0, 1, 'h04, 0, 1, 0, 0);
    add(0, 0, 0,      0, 0, 1, 'hFD, 0, 1, 0, 0);
    add(0, 0, 0,      0, 0, 1, 'hFE, 0, 1, 0, 0);
    add(0, 0, 0,      0, 0, 1, 'hFF, 0, 1, 0, 0);
    add(0, 0, 0,      0, 0, 1, 'h00, 0, 1, 0, 0);
    add(0, 0, 0,      0, 0, 1, 'h01, 1, 0, 0, 0);
    add(0, 0, 0,      0, 0, 1, 'h02, 0, 0, 0, 0);
    add(1, 1, 'h01F4, 0, 0, 1, 'h03, 0, 0, 0, 0);
    add(1, 0, 'h000F, 0, 0, 0, 'h04, 0, 0, 0, 0);
    add(0, 0, 0,      1, 1, 0, 'hF4, 0, 0, 0, 'h00F4);
    add(1, 0, 'h0104, 0, 0, 0, 'hF4, 0, 0, 1, 0);
    add(0, 0, 0,      1, 0, 0, 'h00, 0, 0, 1, 'h0000);
    add(0, 0, 0,      1, 2, 0, 'h00, 0, 0, 1, 'h0001);
    add(1, 15, 'hFFFF, 1, 15, 0, 'h00, 0, 0, 1, 'h0000);
    add(1, 0, 'h0000, 0, 0, 0, 'h00, 0, 0, 0, 0);

    // Reset state
    #1;
    chk("rst_running", running, 0);
    chk("rst_counter", counter, 0);
    chk("rst_auto", auto_start, 0);
    chk("rst_pulse", alarm_pulse, 0);
    chk("rst_armed", armed, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    // Table: counting, stop, wrap with alarm, precedence, reads
    foreach (vecs[i]) begin
      cmd_valid = vecs[i].wr; cmd_addr = vecs[i].waddr; cmd_wdata = vecs[i].wdata;
      rd_en = vecs[i].rd; rd_addr = vecs[i].raddr;
      @(negedge clk);
      cmd_valid = 1'b0; rd_en = 1'b0;
      chk($sformatf("v%0d_running", i), running, vecs[i].e_run);
      chk($sformatf("v%0d_counter", i), counter, vecs[i].e_cnt);
      chk($sformatf("v%0d_pulse", i), alarm_pulse, vecs[i].e_pulse);
      chk($sformatf("v%0d_armed", i), armed, vecs[i].e_armed);
      chk($sformatf("v%0d_auto", i), auto_start, vecs[i].e_auto);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].rd);
      if (vecs[i].rd) chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_rdata);
    end

    // Two channels firing together at 100, third armed at 50 fires only after the wrap
    wr(3, 100);
    wr(4, 100);
    wr(5, 50);
    wr(1, 60);
    wr(0, 'h9);
    chk("seq3_armed_start", armed, 4'b1110);
    bad_cnt = 0; bad_stray = 0;
    for (int t = 1; t <= 250; t++) begin
      @(negedge clk);
      ec = CW'(60 + t - 1);
      if (counter !== ec) bad_cnt++;
      if (t == 41) begin
        chk("seq3_pulse_at_100", alarm_pulse, 4'b0110);
        chk("seq3_armed_after_100", armed, 4'b1000);
      end else if (t == 247) begin
        chk("seq3_pulse_at_50_wrapped", alarm_pulse, 4'b1000);
        chk("seq3_armed_after_50", armed, 4'b0000);
      end else if (alarm_pulse !== '0) begin
        bad_stray++;
      end
    end
    chk("seq3_counter_track_errors", bad_cnt, 0);
    chk("seq3_stray_pulses", bad_stray, 0);

    // Rewrite of ALARM_0 in its match cycle wins; pulse arrives at the new value
    wr(2, 40);
    wr(1, 40);
    wr(0, 'h9);
    wr(2, 200);
    chk("seq5_counter_at_40", counter, 40);
    chk("seq5_no_pulse_at_40", alarm_pulse, 0);
    chk("seq5_rearmed", armed, 4'b0001);
    bad_cnt = 0; bad_stray = 0;
    for (int t = 1; t <= 165; t++) begin
      @(negedge clk);
      ec = CW'(40 + t);
      if (counter !== ec) bad_cnt++;
      if (t == 160) begin
        chk("seq5_pulse_at_200", alarm_pulse, 4'b0001);
        chk("seq5_armed_after_200", armed, 4'b0000);
      end else if (alarm_pulse !== '0) begin
        bad_stray++;
      end
    end
    chk("seq5_counter_track_errors", bad_cnt, 0);
    chk("seq5_stray_pulses", bad_stray, 0);
    rd(0);
    chk("seq5_status_read", rd_data, 'h0001);
    rd(2);
    chk("seq5_alarm0_read", rd_data, 'h00C8);

    // Asynchronous reset between edges while running with auto, armed channel and a read in flight
    wr(3, 'h80);
    wr(0, 'h101);
    @(negedge clk);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = AW'(1);
    @(posedge clk);
    #1;
    chk("seq6_pre_rd_valid", rd_valid, 1);
    chk("seq6_pre_auto", auto_start, 1);
    #1;
    rstn = 1'b0;
    #1;
    rd_en = 1'b0;
    chk("seq6_rst_running", running, 0);
    chk("seq6_rst_counter", counter, 0);
    chk("seq6_rst_auto", auto_start, 0);
    chk("seq6_rst_pulse", alarm_pulse, 0);
    chk("seq6_rst_armed", armed, 0);
    chk("seq6_rst_rd_valid", rd_valid, 0);
    chk("seq6_rst_rd_data", rd_data, 0);
    chk("seq6_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("seq6_cmd_ready_back", cmd_ready, 1);
    rd(1);
    chk("seq6_rd_valid_after", rd_valid, 1);
    chk("seq6_counter_read_zero", rd_data, 0);
    chk("seq6_running_after", running, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
